// File: rtl/spi_sramlike_master.sv
// SPI master for the two-chip-select SRAM-like protocol: an address frame on spi_cs_addr, then a data frame on spi_cs_data.
// Completes in 66*CLK_DIV + 2*CS_GAP + 3 cycles from accept; a single request at a time, req_ready is low while busy.
module spi_sramlike_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rd,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        spi_scl,
    output logic        spi_sdo,
    input  logic        spi_sdi,
    output logic        spi_cs_addr,
    output logic        spi_cs_data
);

    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(CS_GAP + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        GAP1,
        DATA,
        GAP2
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [3:0]      bit_q, bit_d;
    logic            last_q, last_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [15:0]     sh_q, sh_d;
    logic [15:0]     rx_q, rx_d;
    logic            rd_q, rd_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            scl_q, scl_d;
    logic            sdo_q, sdo_d;
    logic            cs_addr_q, cs_addr_d;
    logic            cs_data_q, cs_data_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_rdata_q, rsp_rdata_d;
    logic            req_ready_q, req_ready_d;
    logic            busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        bit_d       = bit_q;
        last_d      = last_q;
        gcnt_d      = gcnt_q;
        sh_d        = sh_q;
        rx_d        = rx_q;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        scl_d       = scl_q;
        sdo_d       = sdo_q;
        cs_addr_d   = cs_addr_q;
        cs_data_d   = cs_data_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        req_ready_d = req_ready_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    rd_d        = req_rd;
                    wdata_d     = req_wdata;
                    sh_d        = {req_rd, 7'b0, req_addr};
                    sdo_d       = req_rd;
                    cs_addr_d   = 1'b0;
                    req_ready_d = 1'b0;
                    hcnt_d      = '0;
                    bit_d       = '0;
                    last_d      = 1'b0;
                    state_d     = ADDR;
                end
            end
            ADDR, DATA: begin
                // Each frame is 33 half-periods: a low lead-in, 16 high/low pulses, and a low tail after the last fall.
                if (hcnt_q == HW'(CLK_DIV - 1)) begin
                    hcnt_d = '0;
                    if (scl_q) begin
                        scl_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            last_d = 1'b1;
                        end else begin
                            bit_d = bit_q + 4'd1;
                            sh_d  = {sh_q[14:0], 1'b0};
                            sdo_d = sh_q[14];
                        end
                    end else if (last_q) begin
                        sdo_d  = 1'b0;
                        gcnt_d = '0;
                        if (state_q == ADDR) begin
                            cs_addr_d = 1'b1;
                            state_d   = GAP1;
                        end else begin
                            cs_data_d   = 1'b1;
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = rd_q ? rx_q : 16'h0000;
                            state_d     = GAP2;
                        end
                    end else begin
                        scl_d = 1'b1;
                        rx_d  = {rx_q[14:0], spi_sdi};
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            GAP1: begin
                if (gcnt_q == GW'(CS_GAP - 1)) begin
                    cs_data_d = 1'b0;
                    sh_d      = rd_q ? 16'h0000 : wdata_q;
                    sdo_d     = rd_q ? 1'b0 : wdata_q[15];
                    rx_d      = '0;
                    hcnt_d    = '0;
                    bit_d     = '0;
                    last_d    = 1'b0;
                    state_d   = DATA;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            GAP2: begin
                // The response cycle precedes the CS_GAP idle cycles, so exit one count later than GAP1.
                if (gcnt_q == GW'(CS_GAP)) begin
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = ~req_ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hcnt_q      <= '0;
            bit_q       <= '0;
            last_q      <= 1'b0;
            gcnt_q      <= '0;
            sh_q        <= '0;
            rx_q        <= '0;
            rd_q        <= 1'b0;
            wdata_q     <= '0;
            scl_q       <= 1'b0;
            sdo_q       <= 1'b0;
            cs_addr_q   <= 1'b1;
            cs_data_q   <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            bit_q       <= bit_d;
            last_q      <= last_d;
            gcnt_q      <= gcnt_d;
            sh_q        <= sh_d;
            rx_q        <= rx_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            scl_q       <= scl_d;
            sdo_q       <= sdo_d;
            cs_addr_q   <= cs_addr_d;
            cs_data_q   <= cs_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign spi_scl     = scl_q;
    assign spi_sdo     = sdo_q;
    assign spi_cs_addr = cs_addr_q;
    assign spi_cs_data = cs_data_q;

endmodule

// File: tb/tb_spi_sramlike_master.sv
// Directed bench for spi_sramlike_master: instance a runs CLK_DIV=2, instance b runs CLK_DIV=1, both with CS_GAP=2.
module tb_spi_sramlike_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_req_valid = 0, a_req_rd = 0, a_sdi = 0;
    logic [7:0]  a_req_addr = 0;
    logic [15:0] a_req_wdata = 0;
    logic        a_req_ready, a_rsp_valid, a_busy, a_scl, a_sdo, a_csa, a_csd;
    logic [15:0] a_rsp_rdata;

    logic        b_req_valid = 0, b_req_rd = 0, b_sdi = 0;
    logic [7:0]  b_req_addr = 0;
    logic [15:0] b_req_wdata = 0;
    logic        b_req_ready, b_rsp_valid, b_busy, b_scl, b_sdo, b_csa, b_csd;
    logic [15:0] b_rsp_rdata;

    spi_sramlike_master #(.CLK_DIV(2), .CS_GAP(2)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_rd(a_req_rd), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .busy(a_busy),
        .spi_scl(a_scl), .spi_sdo(a_sdo), .spi_sdi(a_sdi),
        .spi_cs_addr(a_csa), .spi_cs_data(a_csd)
    );

    spi_sramlike_master #(.CLK_DIV(1), .CS_GAP(2)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_rd(b_req_rd), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
        .spi_scl(b_scl), .spi_sdo(b_sdo), .spi_sdi(b_sdi),
        .spi_cs_addr(b_csa), .spi_cs_data(b_csd)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model and frame monitor for instance a, sampled on the falling clock edge.
    logic        a_csa_p = 1, a_csd_p = 1, a_scl_p = 0;
    logic [15:0] a_cap = 0, a_afr = 0, a_dfr = 0, a_rsp_data = 0, a_slave_word = 0;
    int a_low = 0, a_rises = 0, a_alow = 0, a_dlow = 0, a_arise = 0, a_drise = 0;
    int a_frames = 0, a_rsp_cnt = 0, a_rsp_cyc = 0, a_acc_cyc = 0;
    int a_arise_cyc = 0, a_dfall_cyc = 0, a_viol = 0, a_sidx = -1;

    always @(negedge clk) begin
        if (!a_csa && !a_csd) a_viol++;
        if ((a_csa != a_csa_p || a_csd != a_csd_p) && a_scl) a_viol++;
        if ((a_csa_p && !a_csa) || (a_csd_p && !a_csd)) begin
            a_low = 0; a_rises = 0; a_cap = 0;
        end
        if (a_csa_p && !a_csa) a_frames++;
        if (a_csd_p && !a_csd) begin
            a_dfall_cyc = cyc;
            a_sdi = a_slave_word[15];
            a_sidx = 14;
        end
        if (!a_csa || !a_csd) begin
            a_low++;
            if (a_scl && !a_scl_p) begin
                a_rises++;
                a_cap = {a_cap[14:0], a_sdo};
            end
            if (!a_csd && !a_scl && a_scl_p && a_sidx >= 0) begin
                a_sdi = a_slave_word[a_sidx];
                a_sidx--;
            end
        end
        if (!a_csa_p && a_csa) begin
            a_afr = a_cap; a_alow = a_low; a_arise = a_rises; a_arise_cyc = cyc;
        end
        if (!a_csd_p && a_csd) begin
            a_dfr = a_cap; a_dlow = a_low; a_drise = a_rises;
        end
        if (a_rsp_valid) begin
            a_rsp_cnt++; a_rsp_data = a_rsp_rdata; a_rsp_cyc = cyc;
        end
        if (a_req_valid && a_req_ready) a_acc_cyc = cyc;
        a_csa_p = a_csa; a_csd_p = a_csd; a_scl_p = a_scl;
    end

    // Instance b: spi_sdi is either tied or random; track CS low time, pulse count and SCL period.
    logic        b_csa_p = 1, b_csd_p = 1, b_scl_p = 0, b_rand = 0, b_tie = 0;
    logic [15:0] b_rsp_data = 0;
    int b_low = 0, b_rises = 0, b_low_last = 0, b_rises_last = 0, b_per = 0, b_rise_cyc = 0;
    int b_rsp_cnt = 0, b_viol = 0;

    always @(negedge clk) begin
        b_sdi = b_rand ? 1'($urandom_range(0, 1)) : b_tie;
        if (!b_csa && !b_csd) b_viol++;
        if ((b_csa != b_csa_p || b_csd != b_csd_p) && b_scl) b_viol++;
        if ((b_csa_p && !b_csa) || (b_csd_p && !b_csd)) begin
            b_low = 0; b_rises = 0;
        end
        if (!b_csa || !b_csd) begin
            b_low++;
            if (b_scl && !b_scl_p) begin
                if (b_rises > 0) b_per = cyc - b_rise_cyc;
                b_rise_cyc = cyc;
                b_rises++;
            end
        end
        if ((!b_csa_p && b_csa) || (!b_csd_p && b_csd)) begin
            b_low_last = b_low; b_rises_last = b_rises;
        end
        if (b_rsp_valid) begin
            b_rsp_cnt++; b_rsp_data = b_rsp_rdata;
        end
        b_csa_p = b_csa; b_csd_p = b_csd; b_scl_p = b_scl;
    end

    task automatic issue_a(input logic rd, input logic [7:0] addr, input logic [15:0] wd, input logic hold);
        int n = 0;
        a_req_rd = rd; a_req_addr = addr; a_req_wdata = wd; a_req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!a_req_ready && n < 2000);
        check("accept_a", a_req_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) a_req_valid = 1'b0;
    endtask

    task automatic issue_b(input logic rd, input logic [7:0] addr, input logic [15:0] wd);
        int n = 0;
        b_req_rd = rd; b_req_addr = addr; b_req_wdata = wd; b_req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!b_req_ready && n < 2000);
        check("accept_b", b_req_ready, 1);
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
    endtask

    task automatic wait_rsp_a(input int target);
        int n = 0;
        while (a_rsp_cnt < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("rsp_wait_a", a_rsp_cnt, target);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp_b(input int target);
        int n = 0;
        while (b_rsp_cnt < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("rsp_wait_b", b_rsp_cnt, target);
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        check("rst_scl", a_scl, 0);
        check("rst_sdo", a_sdo, 0);
        check("rst_cs_addr", a_csa, 1);
        check("rst_cs_data", a_csd, 1);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_rsp_rdata", a_rsp_rdata, 0);
        check("rst_req_ready", a_req_ready, 1);
        check("rst_busy", a_busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Write with a spurious req_valid pulse while busy.
        issue_a(1'b0, 8'h05, 16'hA5C3, 1'b0);
        check("busy_after_accept", a_busy, 1);
        repeat (10) @(posedge clk);
        #1 a_req_valid = 1'b1;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        wait_rsp_a(1);
        repeat (10) @(posedge clk);
        #1;
        check("wr_frames", a_frames, 1);
        check("wr_addr_frame", a_afr, 16'h0005);
        check("wr_data_frame", a_dfr, 16'hA5C3);
        check("wr_addr_cs_low", a_alow, 66);
        check("wr_data_cs_low", a_dlow, 66);
        check("wr_addr_rises", a_arise, 16);
        check("wr_data_rises", a_drise, 16);
        check("wr_rdata", a_rsp_data, 0);
        check("wr_rsp_count", a_rsp_cnt, 1);
        check("inter_frame_gap", a_dfall_cyc - a_arise_cyc, 2);

        // Read: slave returns 0x1234.
        a_slave_word = 16'h1234;
        issue_a(1'b1, 8'h80, 16'hFFFF, 1'b0);
        wait_rsp_a(2);
        check("rd_addr_frame", a_afr, 16'h8080);
        check("rd_data_frame", a_dfr, 16'h0000);
        check("rd_rdata", a_rsp_data, 16'h1234);

        // Back-to-back writes with req_valid held.
        issue_a(1'b0, 8'h11, 16'h0101, 1'b1);
        issue_a(1'b0, 8'h22, 16'h0202, 1'b0);
        check("b2b_accept_delay", a_acc_cyc - a_rsp_cyc, 3);
        wait_rsp_a(4);
        check("b2b_frames", a_frames, 4);
        check("b2b_addr_frame", a_afr, 16'h0022);
        check("b2b_data_frame", a_dfr, 16'h0202);
        check("b2b_rdata", a_rsp_data, 0);

        // Reset at the 8th SCL rise of the data frame.
        a_slave_word = 16'hBEEF;
        issue_a(1'b1, 8'h33, 16'h0000, 1'b0);
        n = 0;
        while (!(!a_csd && a_rises == 8) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("reset_point_rises", a_rises, 8);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_cs_addr", a_csa, 1);
        check("midrst_cs_data", a_csd, 1);
        check("midrst_scl", a_scl, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_rsp", a_rsp_cnt, 4);
        check("midrst_req_ready", a_req_ready, 1);

        // CLK_DIV=1: read with spi_sdi tied high.
        b_tie = 1'b1;
        issue_b(1'b1, 8'h01, 16'h0000);
        wait_rsp_b(1);
        check("div1_rdata", b_rsp_data, 16'hFFFF);
        check("div1_cs_low", b_low_last, 33);
        check("div1_rises", b_rises_last, 16);
        check("div1_scl_period", b_per, 2);

        // CLK_DIV=1: write with random spi_sdi.
        b_rand = 1'b1;
        issue_b(1'b0, 8'h7F, 16'h1357);
        wait_rsp_b(2);
        check("div1_wr_rdata", b_rsp_data, 0);
        check("div1_wr_cs_low", b_low_last, 33);

        check("a_cs_overlap_or_scl_at_edge", a_viol, 0);
        check("b_cs_overlap_or_scl_at_edge", b_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_sramlike_master.md
Name: spi_sramlike_master

Overview:
SPI initiator for the two-chip-select SRAM-like register/FIFO/RAM protocol. It turns one host request (read or write, 8-bit address, 16-bit data) into an address frame on spi_cs_addr followed by a data frame on spi_cs_data. For reads it returns the 16-bit word shifted back by the slave. It serves as the FPGA-side bus master for board-to-board links and as the protocol driver in loopback benches against the SPI slave interface.

Parameters:
CLK_DIV, 4, SCL half-period in clk cycles (H); legal range >= 1
CS_GAP, 2, idle clk cycles between frames and after a transaction; legal range >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  host request strobe
req_ready  output  1  high when idle; a request is accepted when req_valid && req_ready
req_rd  input  1  1 = read, 0 = write; sampled on accept
req_addr  input  8  target address; sampled on accept
req_wdata  input  16  write data; sampled on accept and ignored for reads
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  16  read data; valid while rsp_valid is high; 0 for writes
busy  output  1  equals !req_ready
spi_scl  output  1  SPI clock, mode 0 (idle low)
spi_sdo  output  1  master-out serial data
spi_sdi  input  1  master-in serial data
spi_cs_addr  output  1  address-frame chip select, active low
spi_cs_data  output  1  data-frame chip select, active low

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - spi_scl=0, spi_sdo=0, spi_cs_addr=1, spi_cs_data=1.
  - rsp_valid=0, rsp_rdata=0, req_ready=1, FSM in IDLE.
  - Reset mid-transfer aborts the transfer with no rsp_valid.
- All outputs are registered. spi_sdi is used directly and sampled on the internal SCL rising event; no synchronizer is needed because the master owns SCL.
- Frame format: 16 bits, MSB first.
  - Address frame = {req_rd, 7'b0, req_addr}.
  - Data frame = req_wdata for writes, 16'h0000 for reads.
- FSM states: IDLE -> ADDR -> GAP1 -> DATA -> GAP2 -> IDLE.
  - IDLE: req_ready=1. On accept, latch rd/addr/wdata. The next cycle enters ADDR with cs_addr=0 and sdo=frame[15].
  - ADDR/DATA, frame timing with t=0 at the chip-select falling cycle:
    - SCL rises at t = H + 2H*k and falls at t = 2H + 2H*k, for k = 0..15.
    - sdo updates to the next bit on each falling edge, except the 16th.
    - spi_sdi is shifted into rx on each rising edge.
    - cs deasserts at t = 33H with SCL low. CS low time is exactly 33*CLK_DIV cycles and there are exactly 16 SCL pulses per frame.
  - GAP1: both chip selects high and sdo=0 for CS_GAP cycles, then DATA.
  - On the cycle spi_cs_data returns high:
    - rsp_valid=1 for one cycle.
    - rsp_rdata = rx for reads, 0 for writes.
    - Enter GAP2.
  - GAP2: CS_GAP cycles, then IDLE with req_ready=1.
- Only one chip select is ever low at a time; both are never low together.
- req_valid while busy is ignored; there is no queueing. The host must hold req_valid.
- The bit counter is 4 bits, the half-period counter is sized by $clog2(CLK_DIV+1), and counters wrap only under state control.
- The address-frame rx bits are discarded.

Test Plan:
- CLK_DIV=2, CS_GAP=2: write addr 0x05, data 0xA5C3 -> slave model captures address frame 0x0005 and data frame 0xA5C3. Each CS is low for 66 cycles with 16 SCL rises. rsp_valid pulses once with rsp_rdata=0.
- Read addr 0x80, slave drives 0x1234 on spi_sdi during the data frame -> address frame 0x8080; rsp_rdata=0x1234 on the rsp_valid cycle.
- req_valid held high for two writes -> the second is accepted exactly CS_GAP+1 cycles after the first rsp_valid. No req_valid pulse during busy produces an extra transfer.
- rst_n low at the 8th SCL rise of the data frame -> cs_addr and cs_data high and scl low immediately. No rsp_valid; req_ready=1 after release.
- CLK_DIV=1: read with spi_sdi tied to 1 -> rsp_rdata=0xFFFF. SCL period is 2 cycles and CS low time is 33 cycles.
- Write with spi_sdi toggling randomly -> rsp_rdata=0. The checker confirms the chip selects are never simultaneously low and scl=0 at every CS edge.
